// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM fade controller: register map, CTRL bit
// positions, duty width/ceiling, FSM state type and a byte-strobe merge helper.
package pwm_pkg;

  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_TARGET   = 2'd1;
  localparam logic [1:0] REG_STEP_DIV = 2'd2;
  localparam logic [1:0] REG_STATUS   = 2'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_START    = 1;
  localparam int CTRL_CLR_DONE = 2;
  localparam int CTRL_IRQ_EN   = 3;

  localparam int              DUTY_W   = 8;
  localparam logic [DUTY_W-1:0] DUTY_MAX = 8'd255;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } fadeState_e;

  function automatic logic [31:0] applyStrobe(input logic [31:0] oldWord,
                                              input logic [31:0] newWord,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    merged = oldWord;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merged[8*b +: 8] = newWord[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/pwm_step_timer.sv
// Step divider: counts 0..div_i while running and emits a one-cycle tick on
// each wrap; clear_i (or not running) holds the count at zero.
module pwm_step_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear_i,
  input  logic             run_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] count_q, count_d;

  // >= rather than == so a divider lowered below the running count wraps at once
  assign tick_o = run_i && !clear_i && (count_q >= div_i);

  always_comb begin
    count_d = count_q;
    if (clear_i || !run_i || tick_o) begin
      count_d = '0;
    end else begin
      count_d = count_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Memory-mapped duty fader feeding the PWM generator: ramps duty one LSB per
// step toward TARGET. Optional fade-done interrupt under macro PWM_FADE_IRQ_EN.
module pwm_fade_ctrl
  import pwm_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
  parameter int          DIV_W     = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic [31:0] duty_out,
  output logic        busy,
  output logic        irq
);

  fadeState_e        state_q, state_d;
  logic              en_q, en_d;
  logic              done_q, done_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic [DUTY_W-1:0] current_q, current_d;
  logic [DIV_W-1:0]  stepDiv_q, stepDiv_d;
  logic              ready_q;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       duty_q;
  logic              access, wrEn, rdEn, ctrlWrite;
  logic              startPulse, clrPulse, tick, timerClear;
  logic [31:0]       readWord;
  logic              unusedAddrBits;

`ifdef PWM_FADE_IRQ_EN
  logic irqEn_q, irqEn_d;
  logic irq_q, irq_d;
`else
  logic irqEn_q;
  assign irqEn_q = 1'b0;
`endif

  assign unusedAddrBits = ^iomem_addr[1:0];

  // ready_q gates acceptance so a held request is acknowledged at most every other cycle
  assign access     = iomem_valid && (iomem_addr[31:4] == BASE_ADDR[31:4]) && !ready_q;
  assign wrEn       = access && (iomem_wstrb != 4'b0000);
  assign rdEn       = access && (iomem_wstrb == 4'b0000);
  assign ctrlWrite  = wrEn && (iomem_addr[3:2] == REG_CTRL) && iomem_wstrb[0];
  assign startPulse = ctrlWrite && iomem_wdata[CTRL_START];
  assign clrPulse   = ctrlWrite && iomem_wdata[CTRL_CLR_DONE];

  always_comb begin
    en_d      = en_q;
    target_d  = target_q;
    stepDiv_d = stepDiv_q;
`ifdef PWM_FADE_IRQ_EN
    irqEn_d   = irqEn_q;
`endif
    if (wrEn) begin
      case (iomem_addr[3:2])
        REG_CTRL: begin
          if (iomem_wstrb[0]) begin
            en_d = iomem_wdata[CTRL_EN];
`ifdef PWM_FADE_IRQ_EN
            irqEn_d = iomem_wdata[CTRL_IRQ_EN];
`endif
          end
        end
        REG_TARGET: begin
          if (iomem_wstrb[0]) target_d = iomem_wdata[DUTY_W-1:0];
        end
        REG_STEP_DIV: begin
          stepDiv_d = DIV_W'(applyStrobe(32'(stepDiv_q), iomem_wdata, iomem_wstrb));
        end
        default: ;
      endcase
    end
  end

  // CLR_DONE is applied first so a done raised on this same edge survives it
  always_comb begin
    state_d    = state_q;
    current_d  = current_q;
    done_d     = done_q;
    timerClear = 1'b0;
    if (clrPulse) done_d = 1'b0;
    if (!en_d) begin
      state_d   = IDLE;
      current_d = '0;
    end else if (startPulse) begin
      if ((state_q == IDLE) && (current_q == target_q)) begin
        done_d = 1'b1;
      end else begin
        state_d    = RAMP;
        timerClear = 1'b1;
      end
    end else if ((state_q == RAMP) && tick) begin
      if ((current_q < target_q) && (current_q < DUTY_MAX)) begin
        current_d = current_q + DUTY_W'(1);
      end else if ((current_q > target_q) && (current_q > '0)) begin
        current_d = current_q - DUTY_W'(1);
      end
      if (current_d == target_q) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_comb begin
    readWord = '0;
    case (iomem_addr[3:2])
      REG_CTRL:     readWord = {28'b0, irqEn_q, 2'b00, en_q};
      REG_TARGET:   readWord = 32'(target_q);
      REG_STEP_DIV: readWord = 32'(stepDiv_q);
      REG_STATUS:   readWord = {22'b0, done_q, (state_q == RAMP), current_q};
      default:      readWord = '0;
    endcase
    rdata_d = rdEn ? readWord : '0;
  end

`ifdef PWM_FADE_IRQ_EN
  assign irq_d = done_d && irqEn_d;
`endif

  pwm_step_timer #(
    .DIV_W(DIV_W)
  ) u_step_timer (
    .clk    (clk),
    .resetn (resetn),
    .clear_i(timerClear),
    .run_i  (state_q == RAMP),
    .div_i  (stepDiv_q),
    .tick_o (tick)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
      target_q  <= '0;
      current_q <= '0;
      stepDiv_q <= '0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      duty_q    <= '0;
`ifdef PWM_FADE_IRQ_EN
      irqEn_q   <= 1'b0;
      irq_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      done_q    <= done_d;
      target_q  <= target_d;
      current_q <= current_d;
      stepDiv_q <= stepDiv_d;
      ready_q   <= access;
      rdata_q   <= rdata_d;
      duty_q    <= en_d ? 32'(current_d) : '0;
`ifdef PWM_FADE_IRQ_EN
      irqEn_q   <= irqEn_d;
      irq_q     <= irq_d;
`endif
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign duty_out    = duty_q;
  assign busy        = (state_q == RAMP);
`ifdef PWM_FADE_IRQ_EN
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Bench for pwm_fade_ctrl: directed fades plus randomized bus traffic, all
// compared every cycle against a behavioural model of the fader.
module tb_pwm_fade_ctrl;

  localparam logic [31:0] BASE = 32'h0300_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic [31:0] duty_out;
  logic        busy;
  logic        irq;

  int checks = 0;
  int errors = 0;
  bit compareOn = 1'b0;

  // model state: values the DUT outputs must show after each edge
  bit          mEn = 0, mIrqEn = 0, mRamp = 0, mDone = 0, mReady = 0, mReadResp = 0, mIrq = 0;
  int          mTarget = 0, mCur = 0, mDiv = 0, mElapsed = 0;
  logic [31:0] mRdata = '0;

  always #5 clk = ~clk;

  pwm_fade_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .iomem_valid(iomem_valid),
    .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb),
    .iomem_addr (iomem_addr),
    .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata),
    .duty_out   (duty_out),
    .busy       (busy),
    .irq        (irq)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h t=%0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit          acc, wr, start, clr, step, nEn, nIrqEn, nRamp, nDone;
    int          nTarget, nCur, nDiv, nEl;
    logic [31:0] rv;
    if (!resetn) begin
      mEn <= 0; mIrqEn <= 0; mRamp <= 0; mDone <= 0; mReady <= 0; mReadResp <= 0; mIrq <= 0;
      mTarget <= 0; mCur <= 0; mDiv <= 0; mElapsed <= 0; mRdata <= '0;
    end else begin
      acc = iomem_valid && (iomem_addr[31:4] == BASE[31:4]) && !mReady;
      wr  = acc && (iomem_wstrb != 4'b0000);
      nEn = mEn; nIrqEn = mIrqEn; nRamp = mRamp; nDone = mDone;
      nTarget = mTarget; nCur = mCur; nDiv = mDiv; nEl = mElapsed;
      start = 0; clr = 0; rv = '0;
      if (acc && !wr) begin
        case (iomem_addr[3:2])
          2'd0: rv = {28'b0, mIrqEn, 2'b00, mEn};
          2'd1: rv = mTarget;
          2'd2: rv = mDiv;
          default: rv = mCur + (mRamp ? 256 : 0) + (mDone ? 512 : 0);
        endcase
      end
      if (wr) begin
        case (iomem_addr[3:2])
          2'd0: if (iomem_wstrb[0]) begin
            nEn = iomem_wdata[0]; start = iomem_wdata[1]; clr = iomem_wdata[2];
`ifdef PWM_FADE_IRQ_EN
            nIrqEn = iomem_wdata[3];
`endif
          end
          2'd1: if (iomem_wstrb[0]) nTarget = int'(iomem_wdata[7:0]);
          2'd2: begin
            if (iomem_wstrb[0]) nDiv = (nDiv & 32'h0000_FF00) | int'(iomem_wdata[7:0]);
            if (iomem_wstrb[1]) nDiv = (nDiv & 32'h0000_00FF) | (int'(iomem_wdata[15:8]) << 8);
          end
          default: ;
        endcase
      end
      // a step is due once STEP_DIV+1 cycles have passed since the ramp (re)started or last stepped
      step = mRamp && (mElapsed >= mDiv);
      if (clr) nDone = 0;
      if (!nEn) begin
        nRamp = 0; nCur = 0;
      end else if (start) begin
        if (!mRamp && (mCur == mTarget)) nDone = 1;
        else begin nRamp = 1; nEl = 0; end
      end else if (step) begin
        if (mCur < mTarget && mCur < 255) nCur = mCur + 1;
        else if (mCur > mTarget && mCur > 0) nCur = mCur - 1;
        nEl = 0;
        if (nCur == mTarget) begin nRamp = 0; nDone = 1; end
      end else if (mRamp) begin
        nEl = mElapsed + 1;
      end
      mEn <= nEn; mIrqEn <= nIrqEn; mRamp <= nRamp; mDone <= nDone;
      mTarget <= nTarget; mCur <= nCur; mDiv <= nDiv; mElapsed <= nEl;
      mReady <= acc; mReadResp <= acc && !wr; mRdata <= rv;
`ifdef PWM_FADE_IRQ_EN
      mIrq <= nDone && nIrqEn;
`else
      mIrq <= 0;
`endif
    end
  end

  always @(negedge clk) begin
    if (compareOn) begin
      checkOutput("ready", {31'b0, iomem_ready}, {31'b0, mReady});
      if (mReady && mReadResp) checkOutput("rdata", iomem_rdata, mRdata);
      checkOutput("duty", duty_out, mEn ? mCur : 0);
      checkOutput("busy", {31'b0, busy}, {31'b0, mRamp});
      checkOutput("irq", {31'b0, irq}, {31'b0, mIrq});
    end
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, input int hold);
    @(posedge clk); #1;
    iomem_valid = 1'b1; iomem_addr = a; iomem_wstrb = s; iomem_wdata = d;
    repeat (hold) @(posedge clk);
    #1;
    iomem_valid = 1'b0; iomem_wstrb = 4'b0000;
  endtask

  task automatic busWrite(input int off, input logic [31:0] d, input logic [3:0] s);
    applyStimulus(BASE + 32'(off * 4), s, d, 1);
  endtask

  task automatic busRead(input int off, output logic [31:0] d);
    applyStimulus(BASE + 32'(off * 4), 4'b0000, 32'h0, 1);
    d = iomem_rdata;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic waitNotBusy(input int maxCycles);
    int n;
    n = 0;
    while (busy === 1'b1 && n < maxCycles) begin
      waitCycles(1);
      n++;
    end
    checkOutput("busyTimeout", {31'b0, busy}, 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a, d;
    logic [3:0]  s;
    int          kind;
    resetn = 1'b0; iomem_valid = 1'b0; iomem_wstrb = 4'b0000;
    iomem_addr = BASE; iomem_wdata = '0;
    @(posedge clk); #1;
    compareOn = 1'b1;
    @(posedge clk); #1;
    checkOutput("resetDuty", duty_out, 32'h0);
    checkOutput("resetBusy", {31'b0, busy}, 32'h0);
    checkOutput("resetIrq", {31'b0, irq}, 32'h0);
    checkOutput("resetReady", {31'b0, iomem_ready}, 32'h0);
    checkOutput("resetRdata", iomem_rdata, 32'h0);
    resetn = 1'b1;
    busRead(3, rd);
    checkOutput("resetStatus", rd, 32'h0);

    // up-ramp 0 -> 5, one step every 4 cycles
    busWrite(2, 32'd3, 4'hF);
    busWrite(1, 32'd5, 4'hF);
    busWrite(0, 32'h3, 4'h1);
    for (int k = 1; k <= 4; k++) begin
      waitCycles(4);
      checkOutput("upRampDuty", duty_out, 32'(k));
    end
    waitCycles(3);
    checkOutput("upRampBusyHeld", {31'b0, busy}, 32'h1);
    waitCycles(1);
    checkOutput("upRampDuty5", duty_out, 32'd5);
    checkOutput("upRampBusyLow", {31'b0, busy}, 32'h0);
    checkOutput("modelCur5", mCur, 32'd5);
    busRead(3, rd);
    checkOutput("upRampStatus", rd, 32'h0000_0205);

    // down-ramp 5 -> 2, one step every cycle
    busWrite(2, 32'd0, 4'hF);
    busWrite(1, 32'd2, 4'hF);
    busWrite(0, 32'h3, 4'h1);
    for (int k = 4; k >= 2; k--) begin
      waitCycles(1);
      checkOutput("downRampDuty", duty_out, 32'(k));
    end
    checkOutput("downRampBusyLow", {31'b0, busy}, 32'h0);
    waitCycles(3);
    checkOutput("downRampNoUnderflow", duty_out, 32'd2);

    // reverse direction mid-ramp
    busWrite(1, 32'd100, 4'hF);
    busWrite(0, 32'h3, 4'h1);
    waitNotBusy(400);
    checkOutput("reach100", duty_out, 32'd100);
    busWrite(2, 32'd1, 4'hF);
    busWrite(1, 32'd200, 4'hF);
    busWrite(0, 32'h3, 4'h1);
    waitCycles(20);
    busWrite(1, 32'd50, 4'hF);
    waitNotBusy(1000);
    checkOutput("reverseDuty50", duty_out, 32'd50);
    checkOutput("modelCur50", mCur, 32'd50);
    busRead(3, rd);
    checkOutput("reverseStatus", rd, 32'h0000_0232);

    // EN cleared mid-ramp, then a byte-strobed TARGET write
    busWrite(1, 32'd200, 4'hF);
    busWrite(0, 32'h3, 4'h1);
    waitCycles(10);
    busWrite(0, 32'h0, 4'h1);
    checkOutput("enOffDuty", duty_out, 32'h0);
    checkOutput("enOffBusy", {31'b0, busy}, 32'h0);
    busWrite(1, 32'hFFFF_FF10, 4'b0001);
    busRead(1, rd);
    checkOutput("byteTarget", rd, 32'h0000_0010);
    busRead(3, rd);
    checkOutput("enOffStatus", rd, 32'h0000_0200);

    // interrupt: clear done with IRQ_EN set, fade 0 -> 3, then clear again
    busWrite(0, 32'hD, 4'h1);
    checkOutput("irqClearedStart", {31'b0, irq}, 32'h0);
    busWrite(1, 32'd3, 4'hF);
    busWrite(2, 32'd0, 4'hF);
    busWrite(0, 32'hB, 4'h1);
    waitNotBusy(50);
`ifdef PWM_FADE_IRQ_EN
    checkOutput("irqAfterDone", {31'b0, irq}, 32'h1);
`else
    checkOutput("irqAfterDone", {31'b0, irq}, 32'h0);
`endif
    busWrite(0, 32'hD, 4'h1);
    checkOutput("irqAfterClear", {31'b0, irq}, 32'h0);

    // a held request is acknowledged on alternate cycles; a foreign address never
    applyStimulus(BASE + 32'hC, 4'b0000, 32'h0, 3);
    checkOutput("holdReady", {31'b0, iomem_ready}, 32'h1);
    applyStimulus(32'h0400_000C, 4'b0000, 32'h0, 2);
    checkOutput("missReady", {31'b0, iomem_ready}, 32'h0);

    for (int i = 0; i < 300; i++) begin
      kind = int'($urandom_range(0, 99));
      if (kind == 99) begin
        @(posedge clk); #1 resetn = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
      end else begin
        a = BASE | (32'($urandom_range(0, 3)) << 2);
        if (kind < 5) a = a ^ (32'h1 << $urandom_range(4, 31));
        s = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
        d = $urandom();
        if (a[3:2] == 2'd0) begin
          d[0] = ($urandom_range(0, 7) != 0);
          d[2] = d[2] && ($urandom_range(0, 3) == 0);
        end else if (a[3:2] == 2'd2) begin
          d[15:0] = 16'($urandom_range(0, 4));
        end
        applyStimulus(a, s, d, ($urandom_range(0, 9) == 0) ? 2 : 1);
        repeat ($urandom_range(0, 6)) @(posedge clk);
      end
    end
    waitCycles(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_fade_ctrl.md
Name: pwm_fade_ctrl

Overview:
Memory-mapped control stage that sits directly upstream of the PWM generator and drives its 32-bit duty input.
- CPU writes a target duty and a step rate over the SoC iomem bus.
- Block ramps duty_out one LSB at a time toward the target, for LED/motor fades with no CPU polling.
- Reports progress and a sticky done flag through a status register.

Parameters:
BASE_ADDR, 32'h0300_0000, bus base; block decodes iomem_addr[31:4] == BASE_ADDR[31:4]
DIV_W, 16, width of step-divider register and counter
DUTY_MAX, 255, saturating duty ceiling; the PWM stage treats 255 as always-on and 0 as always-off

Ports:
clk  in  1  system clock
resetn  in  1  synchronous, active-low reset
iomem_valid  in  1  bus request
iomem_ready  out  1  one-cycle acknowledge
iomem_wstrb  in  4  byte write strobes; 0 = read
iomem_addr  in  32  byte address
iomem_wdata  in  32  write data
iomem_rdata  out  32  read data, valid while iomem_ready=1
duty_out  out  32  to PWM pwm_in; zero-extended 8-bit duty
busy  out  1  ramp in progress
irq  out  1  fade-done interrupt (see Optional Feature)

Behaviour:
- Reset (resetn=0 at a clk edge): all registers 0; duty_out=0, busy=0, irq=0, iomem_ready=0, iomem_rdata=0; FSM=IDLE.
- Register map, word offsets selected by iomem_addr[3:2]:
  - 0x0 CTRL: b0 EN. b1 START (write-1 pulse, reads 0). b2 CLR_DONE (write-1 pulse, reads 0). b3 IRQ_EN.
  - 0x4 TARGET: [7:0]; upper bits read 0.
  - 0x8 STEP_DIV: [DIV_W-1:0].
  - 0xC STATUS (read-only): [7:0] current duty, b8 busy, b9 done.
- Bus handshake:
  - When iomem_valid=1, the address matches and iomem_ready=0, assert iomem_ready for exactly one cycle on the next edge.
  - The write (per-byte wstrb) or the read capture happens on that same edge.
  - iomem_ready is never high two consecutive cycles.
  - A non-matching address gets no response.
  - Writes to STATUS are ignored.
- Step timing: the divider counter counts 0..STEP_DIV. Each wrap is a step tick, so one step occurs every STEP_DIV+1 cycles. STEP_DIV=0 gives a step every cycle.
- FSM:
  - IDLE:
    - START with EN=1 → RAMP. Divider cleared, busy=1 from the next cycle.
    - If current==TARGET at START: stay IDLE, set done the next cycle, busy never asserts.
  - RAMP:
    - On each tick, current moves ±1 toward TARGET.
    - When the updated current equals TARGET → IDLE, done=1, busy=0 in the same edge.
- Arithmetic: current is 8-bit and saturates at 0 and DUTY_MAX; no wrap-around.
- duty_out = EN ? {24'b0,current} : 0. Registered; one-cycle latency from a current update.
- Boundary cases:
  - TARGET rewritten during RAMP: ramp continues toward the new value, direction re-evaluated on the next tick.
  - TARGET rewritten to the present current: completes on the next tick.
  - START during RAMP: restarts the divider only; current is unchanged.
  - EN cleared mid-ramp: FSM → IDLE, current=0, busy=0, done unchanged.
  - START and CLR_DONE in the same write: clear happens first, then the ramp starts.
  - done set and CLR_DONE on the same edge: done wins (remains 1).
  - resetn low mid-ramp: full reset values on that edge.

Optional Feature:
- Macro: PWM_FADE_IRQ_EN.
- Defined: irq = done & IRQ_EN, registered, level-sensitive; cleared via CLR_DONE or by writing IRQ_EN=0.
- Undefined: irq tied 0, CTRL b3 not stored (reads 0); all other behaviour identical.

Decomposition:
- Shared package pwm_pkg holds:
  - register offsets (CTRL/TARGET/STEP_DIV/STATUS);
  - CTRL bit indices;
  - DUTY_W=8 and DUTY_MAX;
  - FSM state typedef (IDLE, RAMP).
- One natural sub-module: pwm_step_timer, the divider counter with clear input and tick output.

Test Plan:
- Reset, then read STATUS → rdata 0x0000_0000; duty_out=0; iomem_ready pulses exactly one cycle per access.
- EN=1, STEP_DIV=3, TARGET=5, START → duty_out goes 1,2,3,4,5 at 4-cycle spacing; busy low and STATUS.done=1 the same edge duty_out reaches 5.
- Current=5, TARGET=2, STEP_DIV=0, START → 4,3,2 on consecutive cycles; no underflow below 2.
- Mid-ramp (current 100→200), rewrite TARGET=50 → duty reverses to 50 and finishes done=1.
- Mid-ramp, write CTRL EN=0 → duty_out=0 the next cycle, busy=0; byte write wstrb=4'b0001 to TARGET with wdata 0xFFFF_FF10 → TARGET reads 0x10.
- With PWM_FADE_IRQ_EN and IRQ_EN=1 → irq rises after done; write CLR_DONE → irq=0 the next cycle. Without the macro, irq stays 0 throughout.
